s2p_pwm_ctrl: RTL and testbench

- Serial-loaded PWM controller: a 16-bit serial-in shift chain (two 8-bit stages) feeds a storage latch with output enable.
- The latched byte pair sets the duty cycle and period of an on-chip PWM generator.
- Configured by a host or another controller over a 3-wire link (sin, st_clk, clk). sout allows daisy-chaining further blocks.

---
 rtl/s2p_pwm_ctrl_if.sv | 21 ++
 rtl/s2p_pwm_ctrl.sv | 75 +++++++
 tb/tb_s2p_pwm_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/s2p_pwm_ctrl_if.sv
// Host-side link and output pins of the serial-loaded PWM controller.
interface s2p_pwm_ctrl_if #(
  parameter int DW = 8
) ();
  logic            oe_n;
  logic            st_clk;
  logic            sin;
  logic            sout;
  logic [2*DW-1:0] dout;
  logic            pwm_out;

  modport master (
    output oe_n, st_clk, sin,
    input  sout, dout, pwm_out
  );

  modport slave (
    input  oe_n, st_clk, sin,
    output sout, dout, pwm_out
  );
endinterface

// File: rtl/s2p_pwm_ctrl.sv
// Serial shift chain -> storage latch -> glitch-free PWM generator.
// Optional build macro S2P_OE_TRISTATE_EN: dout floats instead of driving 0 when oe_n=1.
module s2p_pwm_ctrl #(
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  s2p_pwm_ctrl_if.slave  bus
);
  localparam int SW = 2 * DW;

  logic [SW-1:0] sr_q,   sr_d;
  logic [SW-1:0] st_q,   st_d;
  logic [DW-1:0] per_q,  per_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] cnt_q,  cnt_d;
  logic          idle_s;
  logic          per_end_s;

  // Next-state for shift chain, latch, shadow registers and counter
  always_comb begin
    sr_d      = {sr_q[SW-2:0], bus.sin};
    st_d      = st_q;
    per_d     = per_q;
    duty_d    = duty_q;
    cnt_d     = cnt_q;
    idle_s    = (per_q == {DW{1'b0}});
    per_end_s = (cnt_q == (per_q - {{(DW-1){1'b0}}, 1'b1}));

    // latch captures the chain as it stood before this edge's shift
    if (bus.st_clk) begin
      st_d = sr_q;
    end else begin
      st_d = st_q;
    end

    // shadows only move at a period boundary (or when idle) to avoid glitches
    if (idle_s || per_end_s) begin
      per_d  = st_q[DW-1:0];
      duty_d = st_q[SW-1:DW];
      cnt_d  = {DW{1'b0}};
    end else begin
      per_d  = per_q;
      duty_d = duty_q;
      cnt_d  = cnt_q + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= {SW{1'b0}};
      st_q   <= {SW{1'b0}};
      per_q  <= {DW{1'b0}};
      duty_q <= {DW{1'b0}};
      cnt_q  <= {DW{1'b0}};
    end else begin
      sr_q   <= sr_d;
      st_q   <= st_d;
      per_q  <= per_d;
      duty_q <= duty_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.sout    = sr_q[SW-1];
  assign bus.pwm_out = (!idle_s) && (cnt_q < duty_q);

`ifdef S2P_OE_TRISTATE_EN
  assign bus.dout = bus.oe_n ? {SW{1'bz}} : st_q;
`else
  assign bus.dout = bus.oe_n ? {SW{1'b0}} : st_q;
`endif

endmodule

// File: tb/tb_s2p_pwm_ctrl.sv
// Directed bench for s2p_pwm_ctrl with a scoreboard of expected outputs.
module tb_s2p_pwm_ctrl;
  logic clk;
  logic rst_n;

  s2p_pwm_ctrl_if #(.DW(8)) bus ();

  s2p_pwm_ctrl #(.DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef S2P_OE_TRISTATE_EN
  localparam logic [15:0] DOUT_OFF = 16'hzzzz;
`else
  localparam logic [15:0] DOUT_OFF = 16'h0000;
`endif

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  bit          hist[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_st;
  int          m_per;
  int          m_duty;
  int          m_ph;
  int          hi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // chain contents implied by every bit shifted in since reset
  function automatic logic [15:0] sr_model();
    logic [15:0] v;
    v = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (hist.size() > i) v[i] = hist[hist.size() - 1 - i];
    end
    return v;
  endfunction

  task automatic push_exp(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // one clock edge: predict what the edge produces, then compare after it
  task automatic tick();
    logic [15:0] sr_now;
    bit          bnd;
    bnd = (m_per == 0) || (m_ph == m_per - 1);
    if (bnd) begin
      m_per  = int'(m_st[7:0]);
      m_duty = int'(m_st[15:8]);
      m_ph   = 0;
    end else begin
      m_ph++;
    end
    if (bus.st_clk) m_st = sr_model();
    hist.push_back(bus.sin);
    sr_now = sr_model();
    push_exp("pwm",  {15'd0, ((m_per != 0) && (m_ph < m_duty))});
    push_exp("sout", {15'd0, sr_now[15]});
    push_exp("dout", bus.oe_n ? DOUT_OFF : m_st);
    @(posedge clk);
    #1;
    chk({15'd0, bus.pwm_out});
    chk({15'd0, bus.sout});
    chk(bus.dout);
  endtask

  task automatic load(input logic [7:0] duty, input logic [7:0] per);
    logic [15:0] w;
    w = {duty, per};
    for (int i = 15; i >= 0; i--) begin
      bus.sin = w[i];
      tick();
    end
    bus.sin    = 1'b0;
    bus.st_clk = 1'b1;
    tick();
    bus.st_clk = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic zeros_now(input string tag);
    push_exp({tag, "_pwm"},  16'h0000);
    push_exp({tag, "_sout"}, 16'h0000);
    push_exp({tag, "_dout"}, bus.oe_n ? DOUT_OFF : 16'h0000);
    chk({15'd0, bus.pwm_out});
    chk({15'd0, bus.sout});
    chk(bus.dout);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.sin    = 1'b1;
    bus.st_clk = 1'b1;
    bus.oe_n   = 1'b0;
    m_st = 16'h0000; m_per = 0; m_duty = 0; m_ph = 0;

    // held in reset with active inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      zeros_now("rst_hold");
    end
    bus.sin    = 1'b0;
    bus.st_clk = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    zeros_now("rst_release");

    // duty=30 period=32
    load(8'd30, 8'd32);
    push_exp("dout_1e20", 16'h1E20);
    chk(bus.dout);
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      hi += int'(bus.pwm_out);
    end
    push_exp("high_cycles", 16'd30);
    chk(16'(hi));
    run(8);

    // output enable only gates the pins
    bus.oe_n = 1'b1;
    #1;
    push_exp("dout_oe_off", DOUT_OFF);
    chk(bus.dout);
    run(5);
    bus.oe_n = 1'b0;
    #1;
    push_exp("dout_oe_on", 16'h1E20);
    chk(bus.dout);

    // strobe lands at cnt=10 after 16 shift edges
    for (int i = 0; i < 64; i++) begin
      if (m_ph == 26) break;
      tick();
    end
    load(8'd4, 8'd8);
    run(60);

    load(8'd0,   8'd10);  run(40);
    load(8'd12,  8'd10);  run(40);
    load(8'd5,   8'd0);   run(20);
    load(8'd255, 8'd255); run(300);

    // asynchronous reset mid-period
    rst_n = 1'b0;
    m_st = 16'h0000; m_per = 0; m_duty = 0; m_ph = 0;
    hist.delete();
    #1;
    zeros_now("rst_mid");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
